bnb_reg_pair: RTL and testbench

- Side-by-side register pair that models the two classic ways of coding a two-flop chain.
- "Blocking" path: the chain collapses to a single register, so d appears at q_blk one clock later.
- "Non-blocking" path: a true DEPTH-stage shift register, so d appears at q_nb DEPTH clocks later.
- Used as a timing reference and as a teaching/self-check block; both paths share one clock and one reset.

---
 rtl/bnb_pkg.sv | 10 +
 rtl/bnb_dff.sv | 22 ++
 rtl/bnb_reg_pair.sv | 71 +++++++
 tb/tb_bnb_reg_pair.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bnb_pkg.sv
// Shared constants for the blocking / non-blocking register pair.
package bnb_pkg;

    // Deepest non-blocking chain the block is meant to be built with (legal DEPTH is 1..MAX_DEPTH).
    localparam int unsigned MAX_DEPTH = 16;

    // Value every register takes while reset is asserted, replicated to the data width.
    localparam bit RST_VAL = 1'b0;

endpackage : bnb_pkg

// File: rtl/bnb_dff.sv
// WIDTH-bit register with asynchronous active-high reset.
module bnb_dff
    import bnb_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on every rising edge; clear immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {WIDTH{RST_VAL}};
        end else begin
            q <= d;
        end
    end

endmodule : bnb_dff

// File: rtl/bnb_reg_pair.sv
// Side-by-side collapsed (1-cycle) and true DEPTH-stage register chains with a mismatch flag.
module bnb_reg_pair
    import bnb_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_blk,
    output logic [WIDTH-1:0] q_nb,
    output logic             differ
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [WIDTH-1:0]            nb_next_c;
    logic                        differ_c;

    // Collapsed chain: "s=d; q=s;" leaves a single register.
    bnb_dff #(.WIDTH(WIDTH)) u_blk (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q_blk)
    );

    // True shift register: one register per stage.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            bnb_dff #(.WIDTH(WIDTH)) u_dff (
                .clk (clk),
                .rst (rst),
                .d   (d),
                .q   (stage[i])
            );
        end else begin : g_tail
            bnb_dff #(.WIDTH(WIDTH)) u_dff (
                .clk (clk),
                .rst (rst),
                .d   (stage[i-1]),
                .q   (stage[i])
            );
        end
    end

    assign q_nb = stage[DEPTH-1];

    // Value q_nb will take on the coming edge (d itself when the chain is one stage long).
    if (DEPTH == 1) begin : g_nb_next_single
        assign nb_next_c = d;
    end else begin : g_nb_next_chain
        assign nb_next_c = stage[DEPTH-2];
    end

    // Compare next-state values so differ lines up with the outputs it describes.
    always_comb begin
        differ_c = 1'b0;
        differ_c = (d != nb_next_c);
    end

    // Register the mismatch flag alongside the data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            differ <= RST_VAL;
        end else begin
            differ <= differ_c;
        end
    end

endmodule : bnb_reg_pair

// File: tb/tb_bnb_reg_pair.sv
// Self-checking bench for bnb_reg_pair: three configurations checked against a history-queue model.
module tb_bnb_reg_pair;

    logic        clk;
    logic        rst;
    logic        d2;
    logic [31:0] d1;
    logic [7:0]  d4;

    logic        q_blk2, q_nb2, differ2;
    logic [31:0] q_blk1, q_nb1;
    logic        differ1;
    logic [7:0]  q_blk4, q_nb4;
    logic        differ4;

    int tests;
    int fails;

    // Per-configuration history of values captured since the last reset (oldest first).
    logic [31:0] h2[$];
    logic [31:0] h1[$];
    logic [31:0] h4[$];

    bnb_reg_pair #(.WIDTH(1), .DEPTH(2)) u_w1d2 (
        .clk (clk), .rst (rst), .d (d2),
        .q_blk (q_blk2), .q_nb (q_nb2), .differ (differ2)
    );

    bnb_reg_pair #(.WIDTH(32), .DEPTH(1)) u_w32d1 (
        .clk (clk), .rst (rst), .d (d1),
        .q_blk (q_blk1), .q_nb (q_nb1), .differ (differ1)
    );

    bnb_reg_pair #(.WIDTH(8), .DEPTH(4)) u_w8d4 (
        .clk (clk), .rst (rst), .d (d4),
        .q_blk (q_blk4), .q_nb (q_nb4), .differ (differ4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit   rb;      // reset before applying this vector
        logic d;
        logic e_blk;
        logic e_nb;
        logic e_dif;
    } vec_t;

    vec_t tbl[13];

    // Value captured `lag` edges ago, or the reset value if not enough edges since reset.
    function automatic logic [31:0] lagged(input logic [31:0] h[$], input int lag);
        if (h.size() >= lag) return h[h.size() - lag];
        return 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] b, n;
        b = lagged(h2, 1); n = lagged(h2, 2);
        chk("w1d2.q_blk", 32'(q_blk2), b);
        chk("w1d2.q_nb", 32'(q_nb2), n);
        chk("w1d2.differ", 32'(differ2), 32'(b != n));
        b = lagged(h1, 1); n = lagged(h1, 1);
        chk("w32d1.q_blk", q_blk1, b);
        chk("w32d1.q_nb", q_nb1, n);
        chk("w32d1.differ", 32'(differ1), 32'(b != n));
        b = lagged(h4, 1); n = lagged(h4, 4);
        chk("w8d4.q_blk", 32'(q_blk4), b);
        chk("w8d4.q_nb", 32'(q_nb4), n);
        chk("w8d4.differ", 32'(differ4), 32'(b != n));
    endtask

    task automatic clear_model();
        h2.delete();
        h1.delete();
        h4.delete();
    endtask

    task automatic push_model();
        h2.push_back(32'(d2));
        h1.push_back(d1);
        h4.push_back(32'(d4));
    endtask

    // Drive inputs at the falling edge, let one rising edge happen, then check all outputs.
    task automatic tick(input logic r, input logic d2v, input logic [31:0] d1v, input logic [7:0] d4v);
        @(negedge clk);
        rst = r;
        d2  = d2v;
        d1  = d1v;
        d4  = d4v;
        if (r) clear_model();
        @(posedge clk);
        if (!r) push_model();
        #2;
        check_all();
    endtask

    // Short reset pulse well clear of any edge, then one edge with d held.
    task automatic async_pulse();
        @(negedge clk);
        #1 rst = 1'b1;
        clear_model();
        #1;
        chk("async.q_blk2", 32'(q_blk2), 32'd0);
        chk("async.q_nb2", 32'(q_nb2), 32'd0);
        chk("async.q_nb4", 32'(q_nb4), 32'd0);
        check_all();
        #1 rst = 1'b0;
        @(posedge clk);
        push_model();
        #2;
        check_all();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        d2 = 1'b0;
        d1 = 32'd0;
        d4 = 8'd0;

        // Reset held with d=1 over three edges.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
            chk("rst.q_blk2", 32'(q_blk2), 32'd0);
            chk("rst.differ2", 32'(differ2), 32'd0);
        end

        // Build nonzero state, then assert reset asynchronously mid-cycle.
        tick(1'b0, 1'b1, 32'h1234_5678, 8'h5A);
        tick(1'b0, 1'b1, 32'h9ABC_DEF0, 8'hC3);
        @(negedge clk);
        #1 rst = 1'b1;
        clear_model();
        #1;
        chk("midrst.q_blk2", 32'(q_blk2), 32'd0);
        chk("midrst.q_nb2", 32'(q_nb2), 32'd0);
        chk("midrst.q_blk4", 32'(q_blk4), 32'd0);
        check_all();

        // Vector table: single pulse, then the 8-edge pattern (WIDTH=1, DEPTH=2).
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rb) tick(1'b1, 1'b0, 32'd0, 8'd0);
            tick(1'b0, tbl[i].d, $urandom, 8'($urandom));
            chk($sformatf("tbl%0d.q_blk", i), 32'(q_blk2), 32'(tbl[i].e_blk));
            chk($sformatf("tbl%0d.q_nb", i), 32'(q_nb2), 32'(tbl[i].e_nb));
            chk($sformatf("tbl%0d.differ", i), 32'(differ2), 32'(tbl[i].e_dif));
        end

        // Reset mid-stream: four edges of d=1, reset pulse, then d stays 1.
        tick(1'b1, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 32'd1, 8'd1);
        async_pulse();
        chk("midstream.q_blk2", 32'(q_blk2), 32'd1);
        chk("midstream.q_nb2", 32'(q_nb2), 32'd0);
        chk("midstream.q_nb4", 32'(q_nb4), 32'd0);
        tick(1'b0, 1'b1, 32'd1, 8'd1);
        chk("midstream2.q_nb2", 32'(q_nb2), 32'd1);

        // WIDTH=8 DEPTH=4 sequence.
        tick(1'b1, 1'b0, 32'd0, 8'd0);
        tick(1'b0, 1'b0, 32'd0, 8'hA5);
        chk("w8.e1.q_blk", 32'(q_blk4), 32'hA5);
        tick(1'b0, 1'b0, 32'd0, 8'h3C);
        chk("w8.e2.q_blk", 32'(q_blk4), 32'h3C);
        tick(1'b0, 1'b0, 32'd0, 8'hFF);
        chk("w8.e3.q_blk", 32'(q_blk4), 32'hFF);
        chk("w8.e3.q_nb", 32'(q_nb4), 32'h00);
        tick(1'b0, 1'b0, 32'd0, 8'h00);
        chk("w8.e4.q_blk", 32'(q_blk4), 32'h00);
        chk("w8.e4.q_nb", 32'(q_nb4), 32'hA5);
        tick(1'b0, 1'b0, 32'd0, 8'h00);
        chk("w8.e5.q_nb", 32'(q_nb4), 32'h3C);
        tick(1'b0, 1'b0, 32'd0, 8'h00);
        chk("w8.e6.q_nb", 32'(q_nb4), 32'hFF);
        tick(1'b0, 1'b0, 32'd0, 8'h00);
        chk("w8.e7.q_nb", 32'(q_nb4), 32'h00);

        // Random streams with occasional resets; DEPTH=1 must never differ.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_pulse();
            end else begin
                tick(($urandom_range(0, 49) == 0), 1'($urandom), $urandom, 8'($urandom));
            end
            chk("rand.w32d1.eq", 32'(q_blk1 == q_nb1), 32'd1);
            chk("rand.w32d1.differ", 32'(differ1), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_bnb_reg_pair
